// File: rtl/des_round_engine.sv
// Iterative DES Feistel round engine placed between IP and FP; one round is
// expand+key-mix, an optional registered S-box stage, then the Feistel update.
module des_round_engine #(
  parameter int NUM_ROUNDS = 16,
  parameter int SBOX_REG   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic        in_decrypt,
  output logic [3:0]  key_idx,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_l,
  output logic [31:0] out_r
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XK   = 3'd1,
    S_SB   = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS - 1);

  // Each entry holds one S-box: 64 nibbles, row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
            r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
  endfunction

  // Row is formed from the outer bits, column from the middle four.
  function automatic logic [3:0] sbox(input int j, input logic [5:0] b);
    logic [5:0]   idx;
    logic [255:0] tbl;
    int           pos;
    idx = {b[5], b[0], b[4:1]};
    pos = 252 - 4 * int'(idx);
    tbl = SBOX_TBL[j];
    return tbl[pos +: 4];
  endfunction

  function automatic logic [31:0] sbox_all(input logic [47:0] x);
    logic [31:0] s;
    s = 32'h0000_0000;
    for (int j = 0; j < 8; j++) begin
      s[28 - 4 * j +: 4] = sbox(j, x[42 - 6 * j +: 6]);
    end
    return s;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  function automatic logic [3:0] round_key_idx(input logic [3:0] rc, input logic dec);
    logic [3:0] k;
    if (dec) begin
      k = LAST_RC - rc;
    end else begin
      k = rc;
    end
    return k;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [47:0] dk_q, dk_d;
  logic [31:0] sq_q, sq_d;
  logic [3:0]  rc_q, rc_d;
  logic        mode_q, mode_d;
  logic [3:0]  key_idx_q, key_idx_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_l_q, out_l_d;
  logic [31:0] out_r_q, out_r_d;
  logic [31:0] sb_in_s;
  logic [31:0] f_s;

  // Round function output feeding the Feistel update.
  always_comb begin
    if (SBOX_REG != 0) begin
      sb_in_s = sq_q;
    end else begin
      sb_in_s = sbox_all(dk_q);
    end
    f_s = perm_p(sb_in_s);
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    dk_d        = dk_q;
    sq_d        = sq_q;
    rc_d        = rc_q;
    mode_d      = mode_q;
    key_idx_d   = key_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          l_d        = in_l;
          r_d        = in_r;
          mode_d     = in_decrypt;
          rc_d       = 4'd0;
          key_idx_d  = round_key_idx(4'd0, in_decrypt);
          in_ready_d = 1'b0;
          state_d    = S_XK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XK: begin
        dk_d = expand(r_q) ^ subkey;
        if (SBOX_REG != 0) begin
          state_d = S_SB;
        end else begin
          state_d = S_UPD;
        end
      end
      S_SB: begin
        sq_d    = sbox_all(dk_q);
        state_d = S_UPD;
      end
      S_UPD: begin
        l_d = r_q;
        r_d = l_q ^ f_s;
        if (rc_q == LAST_RC) begin
          out_valid_d = 1'b1;
          out_l_d     = l_q ^ f_s;
          out_r_d     = r_q;
          key_idx_d   = 4'd0;
          state_d     = S_DONE;
        end else begin
          rc_d      = rc_q + 4'd1;
          key_idx_d = round_key_idx(rc_q + 4'd1, mode_q);
          state_d   = S_XK;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_l_d     = 32'h0000_0000;
          out_r_d     = 32'h0000_0000;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_l_d     = 32'h0000_0000;
        out_r_d     = 32'h0000_0000;
        key_idx_d   = 4'd0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      l_q         <= 32'h0000_0000;
      r_q         <= 32'h0000_0000;
      dk_q        <= 48'h0000_0000_0000;
      sq_q        <= 32'h0000_0000;
      rc_q        <= 4'd0;
      mode_q      <= 1'b0;
      key_idx_q   <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_l_q     <= 32'h0000_0000;
      out_r_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      dk_q        <= dk_d;
      sq_q        <= sq_d;
      rc_q        <= rc_d;
      mode_q      <= mode_d;
      key_idx_q   <= key_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign key_idx   = key_idx_q;
  assign out_valid = out_valid_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: three instances (defaults, combinational S-boxes,
// single round) checked against a table-driven DES model with its own key schedule.
module tb_des_round_engine;

  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                              12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                              22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB_T [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [31:0] in_l       [3];
  logic [31:0] in_r       [3];
  logic        in_decrypt [3];
  logic [3:0]  key_idx    [3];
  logic [47:0] subkey     [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [31:0] out_l      [3];
  logic [31:0] out_r      [3];
  logic [47:0] ks         [3][16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    des_round_engine #(
      .NUM_ROUNDS((g == 2) ? 1 : 16),
      .SBOX_REG  ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_l      (in_l[g]),
      .in_r      (in_r[g]),
      .in_decrypt(in_decrypt[g]),
      .key_idx   (key_idx[g]),
      .subkey    (subkey[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_l     (out_l[g]),
      .out_r     (out_r[g])
    );
    assign subkey[g] = ks[g][key_idx[g]];
  end

  function automatic int nr_of(input int u);
    return (u == 2) ? 1 : 16;
  endfunction

  function automatic int cpr_of(input int u);
    return (u == 1) ? 2 : 3;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b;
    int          row, col;
    for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[42 - 6 * j +: 6];
      row = 2 * int'(b[5]) + int'(b[0]);
      col = int'(b[4:1]);
      s[28 - 4 * j +: 4] = 4'(SB_T[j * 64 + row * 16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_T[i]];
    return p;
  endfunction

  function automatic logic [63:0] des_ref(input int u, input logic [31:0] l0,
                                          input logic [31:0] r0, input logic dec);
    logic [31:0] l, r, t;
    int          nr;
    nr = nr_of(u);
    l  = l0;
    r  = r0;
    for (int i = 0; i < nr; i++) begin
      t = l ^ f_ref(r, ks[u][dec ? nr - 1 - i : i]);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  task automatic make_keys(input int u, input logic [63:0] key);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int s = 0; s < SH_T[rnd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2_T[i]];
      ks[u][rnd] = k;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; stays in step with negedges throughout.
  task automatic run_block(input int u, input logic [31:0] l, input logic [31:0] r,
                           input logic dec, input int bp);
    logic [63:0] exp;
    logic [31:0] hl, hr;
    int          n, c, kerr, berr, lat, cpr, nr, ek;
    exp = des_ref(u, l, r, dec);
    nr  = nr_of(u);
    cpr = cpr_of(u);
    lat = nr * cpr;
    in_valid[u]   = 1'b1;
    in_l[u]       = l;
    in_r[u]       = r;
    in_decrypt[u] = dec;
    n = 0;
    while (in_ready[u] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_accept_ready", u), 64'(in_ready[u]), 64'd1);
    @(negedge clk);
    in_valid[u]   = 1'b0;
    in_l[u]       = $urandom;
    in_r[u]       = $urandom;
    in_decrypt[u] = 1'($urandom);
    c    = 0;
    kerr = 0;
    while (out_valid[u] !== 1'b1 && c < lat + 8) begin
      ek = dec ? (nr - 1 - c / cpr) : (c / cpr);
      if (key_idx[u] !== 4'(ek) || in_ready[u] !== 1'b0 ||
          out_l[u] !== 32'h0 || out_r[u] !== 32'h0) kerr++;
      @(negedge clk);
      c++;
    end
    chk($sformatf("u%0d_latency", u), 64'(c), 64'(lat));
    chk($sformatf("u%0d_round_seq_errs", u), 64'(kerr), 64'd0);
    chk($sformatf("u%0d_result", u), {out_l[u], out_r[u]}, exp);
    chk($sformatf("u%0d_done_key_idx", u), 64'(key_idx[u]), 64'd0);
    hl   = out_l[u];
    hr   = out_r[u];
    berr = 0;
    for (int i = 0; i < bp; i++) begin
      in_valid[u] = 1'b1;
      in_l[u]     = $urandom;
      in_r[u]     = $urandom;
      @(negedge clk);
      if (out_valid[u] !== 1'b1 || out_l[u] !== hl || out_r[u] !== hr ||
          in_ready[u] !== 1'b0) berr++;
    end
    if (bp > 0) chk($sformatf("u%0d_backpressure_errs", u), 64'(berr), 64'd0);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk($sformatf("u%0d_post_hs_flags", u), 64'({out_valid[u], in_ready[u]}), 64'b01);
    chk($sformatf("u%0d_post_hs_data", u), {out_l[u], out_r[u]}, 64'h0);
  endtask

  initial begin
    int c, vis;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid[u]   = 1'b0;
      in_l[u]       = 32'h0;
      in_r[u]       = 32'h0;
      in_decrypt[u] = 1'b0;
      out_ready[u]  = 1'b0;
      for (int i = 0; i < 16; i++) ks[u][i] = 48'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_reset_flags", u), 64'({in_ready[u], out_valid[u]}), 64'b10);
      chk($sformatf("u%0d_reset_data", u), {out_l[u], out_r[u]}, 64'h0);
      chk($sformatf("u%0d_reset_key_idx", u), 64'(key_idx[u]), 64'd0);
    end

    // Textbook key and vectors.
    make_keys(0, 64'h1334_5779_9BBC_DFF1);
    make_keys(1, 64'h1334_5779_9BBC_DFF1);
    chk("model_k1", 64'(ks[0][0]), 64'h1B02_EFFC_7072);
    chk("model_enc", des_ref(0, 32'hCC00_CCFF, 32'hF0AA_F0AA, 1'b0), 64'h0A4C_D995_4342_3234);
    chk("model_dec", des_ref(0, 32'h0A4C_D995, 32'h4342_3234, 1'b1), 64'hCC00_CCFF_F0AA_F0AA);
    chk("model_one_round", des_ref(2, 32'h0, 32'h0, 1'b0), 64'hD8D8_DBBC_0000_0000);
    run_block(0, 32'hCC00_CCFF, 32'hF0AA_F0AA, 1'b0, 0);
    run_block(0, 32'h0A4C_D995, 32'h4342_3234, 1'b1, 0);
    run_block(1, 32'hCC00_CCFF, 32'hF0AA_F0AA, 1'b0, 0);
    run_block(2, 32'h0, 32'h0, 1'b0, 0);

    // Backpressure, then a block that was held off until the handshake.
    run_block(0, $urandom, $urandom, 1'b0, 10);
    run_block(0, $urandom, $urandom, 1'b1, 0);

    // Reset in round 7 of a block in flight.
    in_valid[0]   = 1'b1;
    in_l[0]       = $urandom;
    in_r[0]       = $urandom;
    in_decrypt[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    c = 0;
    while (c < 7 * 3 + 1) begin
      @(negedge clk);
      c++;
    end
    chk("rst_mid_key_idx_before", 64'(key_idx[0]), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_flags", 64'({in_ready[0], out_valid[0]}), 64'b10);
    chk("rst_mid_data", {out_l[0], out_r[0]}, 64'h0);
    chk("rst_mid_key_idx", 64'(key_idx[0]), 64'd0);
    vis = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) vis++;
    end
    chk("rst_mid_no_output", 64'(vis), 64'd0);
    run_block(0, 32'hCC00_CCFF, 32'hF0AA_F0AA, 1'b0, 0);

    // Random keys and blocks on every instance.
    for (int t = 0; t < 6; t++) begin
      for (int u = 0; u < 3; u++) begin
        make_keys(u, {$urandom, $urandom});
        run_block(u, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_round_engine.md
# des_round_engine

Iterative DES Feistel round engine that applies NUM_ROUNDS rounds to a 64-bit block that has already passed the initial permutation. It supports encrypt and decrypt per block and a valid/ready handshake on both sides. It requests subkeys by index from the external key schedule and contains the expansion, key-XOR, eight S-box and P-permutation stages. An optional S-box register stage serves timing closure. It sits between the IP and FP stages of the cipher top level and replaces the stand-alone F-function instance.

## Interface
- NUM_ROUNDS, 16, rounds per block; legal range 1..16.
- SBOX_REG, 1, 1 = registered S-box outputs (3 cycles/round); 0 = combinational S-boxes (2 cycles/round).
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block.
- in_l  in  32  left half after IP (L0).
- in_r  in  32  right half after IP (R0).
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- key_idx  out  4  subkey index requested this cycle.
- subkey  in  48  subkey for key_idx; combinational from key schedule, valid in the same cycle.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_l  out  32  R_n (final swap applied).
- out_r  out  32  L_n.

## Operation
- FSM states: IDLE, XK (expand + key XOR), SB (S-box register; only present when SBOX_REG=1), UPD (Feistel update), DONE.
- IDLE: in_ready=1. When in_valid&in_ready:
  - load L←in_l, R←in_r.
  - latch mode←in_decrypt.
  - round counter rc←0.
  - go to XK.
- key_idx:
  - encrypt: key_idx = rc.
  - decrypt: key_idx = NUM_ROUNDS-1-rc.
  - held constant for all cycles of a round; 0 in IDLE/DONE.
- XK: dk ← E(R) XOR subkey.
  - E is the standard 48-bit DES expansion; its MSB is R bit 0 and its LSB is R bit 31.
  - Next state is SB if SBOX_REG, else UPD.
- SB: sq ← S(dk), the eight S-box outputs concatenated with S1 in [31:28].
  - S-box j uses bits 6j..6j+5 counted from the MSB: row = {outer bits}, col = middle four bits.
- UPD: f = P(SBOX_REG ? sq : S(dk)), where P is the standard DES P-permutation.
  - L←R; R←L XOR f.
  - If rc==NUM_ROUNDS-1 go to DONE, else rc←rc+1 and go to XK.
- DONE: out_valid=1, out_l=R, out_r=L. Stay until out_ready; then go to IDLE.
- in_ready is 1 only in IDLE. The engine does not accept a new block until the result has been taken; there is no overlap.
- in_l/in_r/in_decrypt are ignored outside the accept cycle.
- out_l/out_r are 0 whenever out_valid=0.

## Timing
- Cycles per round CPR = 2+SBOX_REG.
- Latency: out_valid rises NUM_ROUNDS*CPR cycles after the accept edge. Defaults give 48 cycles.
- Back-to-back: after the out handshake edge, in_ready=1 the next cycle. Minimum block period is NUM_ROUNDS*CPR+2 cycles.
- out_valid held with stable out_l/out_r while out_ready=0. There is no timeout.
- out_valid and out_ready both 1 in DONE: handshake completes that edge.
- Reset values:
  - in_ready=1, out_valid=0, out_l=out_r=0, key_idx=0.
  - L, R, dk, sq, rc, mode all 0; state IDLE.
- Reset mid-operation: the block in flight is discarded with no output. in_ready=1 the cycle after rst deasserts.
- rst has priority over any handshake in the same cycle.
- subkey changes in mid-round must not corrupt a round. subkey is only sampled in XK.

## Test plan
- Encrypt, defaults:
  - Stimulus: in_l=CC00CCFF, in_r=F0AAF0AA; bench key schedule for key 133457799BBCDFF1.
  - Required: out_l=0A4CD995, out_r=43423234; out_valid exactly 48 cycles after accept; key_idx steps 0..15.
- Decrypt: in_l=0A4CD995, in_r=43423234, in_decrypt=1, same key → out_l=CC00CCFF, out_r=F0AAF0AA; key_idx steps 15..0.
- SBOX_REG=0: repeat the encrypt vector → identical result at 32 cycles; key_idx holds for 2 cycles per round.
- Backpressure: out_ready=0 for 10 cycles in DONE.
  - Required: outputs stable and in_ready=0 throughout.
  - A second in_valid block is accepted only after the handshake; its result is correct.
- Reset mid-block: assert rst during round 7 → no out_valid, outputs all 0. A following block completes with the correct result.
- NUM_ROUNDS=1: in_l=0, in_r=0, subkey=0 → out_r=0, out_l=P(S(0)) = D8D8DBBC; latency 3 cycles.
